// File: rtl/uart_rx_cfg_if.sv
// Host-side bundle for the configurable UART receiver: serial input, runtime
// configuration, the rdy/clr_rdy handshake and the received word with its error flags.
interface uart_rx_cfg_if #(
  parameter int DATA_BITS = 8,
  parameter int BAUD_W    = 13
);
  logic                 RX;
  logic [BAUD_W-1:0]    baud_rate;
  logic [1:0]           parity_mode;
  logic                 two_stop;
  logic                 clr_rdy;
  logic [DATA_BITS-1:0] rx_data;
  logic                 rdy;
  logic                 parity_err;
  logic                 frame_err;
  logic                 overrun;

  modport master (
    output RX, baud_rate, parity_mode, two_stop, clr_rdy,
    input  rx_data, rdy, parity_err, frame_err, overrun
  );

  modport slave (
    input  RX, baud_rate, parity_mode, two_stop, clr_rdy,
    output rx_data, rdy, parity_err, frame_err, overrun
  );
endinterface

// File: rtl/uart_rx_cfg.sv
// Runtime-configurable UART receiver: mid-bit sampling, optional parity, one or two
// stop bits, false-start rejection and a sticky rdy with parity/framing/overrun flags.
module uart_rx_cfg #(
  parameter int DATA_BITS = 8,
  parameter int BAUD_W    = 13
) (
  input  logic         clk,
  input  logic         rst,
  uart_rx_cfg_if.slave bus
);
  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PARITY, S_STOP1, S_STOP2, S_COMPLETE
  } state_t;

  state_t               state_q, state_d;
  logic [1:0]           sync_q, sync_d;
  logic                 armed_q, armed_d;
  logic [BAUD_W-1:0]    cnt_q, cnt_d;
  logic [BAUD_W-1:0]    baud_q, baud_d;
  logic [1:0]           pmode_q, pmode_d;
  logic                 two_q, two_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [3:0]           bit_cnt_q, bit_cnt_d;
  logic                 perr_f_q, perr_f_d;
  logic                 ferr_f_q, ferr_f_d;
  logic [DATA_BITS-1:0] rx_data_q, rx_data_d;
  logic                 rdy_q, rdy_d;
  logic                 parity_err_q, parity_err_d;
  logic                 frame_err_q, frame_err_d;
  logic                 overrun_q, overrun_d;

  logic rx_s;
  logic strobe;
  logic start_det;
  logic par_en;
  logic par_xor;

  assign rx_s      = sync_q[1];
  assign sync_d    = {sync_q[0], bus.RX};
  assign strobe    = (state_q != S_IDLE) && (cnt_q == '0);
  // armed_q keeps a held-low line (break) from re-triggering until it has gone high
  assign start_det = (state_q == S_IDLE) && armed_q && !rx_s;
  assign par_en    = (pmode_q == 2'b01) || (pmode_q == 2'b10);
  assign par_xor   = (^shift_q) ^ rx_s;

  always_comb begin
    cnt_d = cnt_q;
    if (start_det) begin
      cnt_d = bus.baud_rate >> 1;
    end else if (state_q != S_IDLE) begin
      cnt_d = (cnt_q == '0) ? baud_q - BAUD_W'(1) : cnt_q - BAUD_W'(1);
    end
  end

  always_comb begin
    state_d   = state_q;
    armed_d   = armed_q;
    baud_d    = baud_q;
    pmode_d   = pmode_q;
    two_d     = two_q;
    shift_d   = shift_q;
    bit_cnt_d = bit_cnt_q;
    perr_f_d  = perr_f_q;
    ferr_f_d  = ferr_f_q;

    case (state_q)
      S_IDLE: begin
        armed_d = armed_q | rx_s;
        if (start_det) begin
          state_d  = S_START;
          baud_d   = bus.baud_rate;
          pmode_d  = bus.parity_mode;
          two_d    = bus.two_stop;
          perr_f_d = 1'b0;
          ferr_f_d = 1'b0;
        end
      end
      S_START: begin
        if (strobe) begin
          if (rx_s) begin
            state_d = S_IDLE;
          end else begin
            state_d   = S_DATA;
            bit_cnt_d = 4'd0;
          end
        end
      end
      S_DATA: begin
        if (strobe) begin
          shift_d   = {rx_s, shift_q[DATA_BITS-1:1]};
          bit_cnt_d = bit_cnt_q + 4'd1;
          if (bit_cnt_q == 4'(DATA_BITS - 1)) begin
            state_d = par_en ? S_PARITY : S_STOP1;
          end
        end
      end
      S_PARITY: begin
        if (strobe) begin
          perr_f_d = (pmode_q == 2'b01) ? par_xor : ~par_xor;
          state_d  = S_STOP1;
        end
      end
      S_STOP1: begin
        if (strobe) begin
          if (!rx_s) ferr_f_d = 1'b1;
          state_d = two_q ? S_STOP2 : S_COMPLETE;
        end
      end
      S_STOP2: begin
        if (strobe) begin
          if (!rx_s) ferr_f_d = 1'b1;
          state_d = S_COMPLETE;
        end
      end
      S_COMPLETE: begin
        armed_d = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Commit overrides a coincident clr_rdy; that frame then cannot flag overrun.
  always_comb begin
    rx_data_d    = rx_data_q;
    rdy_d        = rdy_q;
    parity_err_d = parity_err_q;
    frame_err_d  = frame_err_q;
    overrun_d    = overrun_q;
    if (bus.clr_rdy) begin
      rdy_d        = 1'b0;
      parity_err_d = 1'b0;
      frame_err_d  = 1'b0;
      overrun_d    = 1'b0;
    end
    if (state_q == S_COMPLETE) begin
      rx_data_d    = shift_q;
      parity_err_d = perr_f_q;
      frame_err_d  = ferr_f_q;
      rdy_d        = 1'b1;
      overrun_d    = bus.clr_rdy ? 1'b0 : (overrun_q | rdy_q);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      sync_q       <= 2'b11;
      armed_q      <= 1'b0;
      cnt_q        <= '0;
      baud_q       <= '0;
      pmode_q      <= 2'b00;
      two_q        <= 1'b0;
      shift_q      <= '1;
      bit_cnt_q    <= 4'd0;
      perr_f_q     <= 1'b0;
      ferr_f_q     <= 1'b0;
      rx_data_q    <= '0;
      rdy_q        <= 1'b0;
      parity_err_q <= 1'b0;
      frame_err_q  <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      sync_q       <= sync_d;
      armed_q      <= armed_d;
      cnt_q        <= cnt_d;
      baud_q       <= baud_d;
      pmode_q      <= pmode_d;
      two_q        <= two_d;
      shift_q      <= shift_d;
      bit_cnt_q    <= bit_cnt_d;
      perr_f_q     <= perr_f_d;
      ferr_f_q     <= ferr_f_d;
      rx_data_q    <= rx_data_d;
      rdy_q        <= rdy_d;
      parity_err_q <= parity_err_d;
      frame_err_q  <= frame_err_d;
      overrun_q    <= overrun_d;
    end
  end

  assign bus.rx_data    = rx_data_q;
  assign bus.rdy        = rdy_q;
  assign bus.parity_err = parity_err_q;
  assign bus.frame_err  = frame_err_q;
  assign bus.overrun    = overrun_q;
endmodule

// File: tb/tb_uart_rx_cfg.sv
// Self-checking bench for uart_rx_cfg: vector table, hand-written corner sequences,
// and randomized frames scored against a bit-level parity/framing model.
module tb_uart_rx_cfg;
  logic        clk;
  logic        rst;
  logic        line;
  logic        sel5;
  logic [12:0] cfg_baud;
  logic [1:0]  cfg_pmode;
  logic        cfg_two;
  logic        clr;
  logic        scramble;
  logic        clr_in_stop;
  logic        clr_seen;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int rise_cnt = 0;
  int rise_cyc = 0;
  int start_cyc = 0;
  logic prev_rdy = 1'b0;

  uart_rx_cfg_if #(.DATA_BITS(8), .BAUD_W(13)) bus8 ();
  uart_rx_cfg_if #(.DATA_BITS(5), .BAUD_W(13)) bus5 ();

  assign bus8.RX          = sel5 ? 1'b1 : line;
  assign bus8.baud_rate   = cfg_baud;
  assign bus8.parity_mode = cfg_pmode;
  assign bus8.two_stop    = cfg_two;
  assign bus8.clr_rdy     = clr;
  assign bus5.RX          = sel5 ? line : 1'b1;
  assign bus5.baud_rate   = cfg_baud;
  assign bus5.parity_mode = cfg_pmode;
  assign bus5.two_stop    = cfg_two;
  assign bus5.clr_rdy     = clr;

  uart_rx_cfg #(.DATA_BITS(8), .BAUD_W(13)) dut8 (.clk(clk), .rst(rst), .bus(bus8));
  uart_rx_cfg #(.DATA_BITS(5), .BAUD_W(13)) dut5 (.clk(clk), .rst(rst), .bus(bus5));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (bus8.rdy && !prev_rdy) begin
      rise_cnt <= rise_cnt + 1;
      rise_cyc <= cyc;
    end
    prev_rdy <= bus8.rdy;
  end

  initial begin
    repeat (80000) @(posedge clk);
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  typedef struct {
    logic [7:0] data;
    int         pm;
    int         pbit;
    int         two;
    int         low2;
    logic [7:0] exp_data;
    logic       exp_perr;
    logic       exp_ferr;
  } vec_t;

  vec_t vecs[10];

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic [7:0] d, input logic pe,
                         input logic fe, input logic r, input logic ov);
    chk({tag, ".rx_data"}, 32'(bus8.rx_data), 32'(d));
    chk({tag, ".parity_err"}, 32'(bus8.parity_err), 32'(pe));
    chk({tag, ".frame_err"}, 32'(bus8.frame_err), 32'(fe));
    chk({tag, ".rdy"}, 32'(bus8.rdy), 32'(r));
    chk({tag, ".overrun"}, 32'(bus8.overrun), 32'(ov));
  endtask

  task automatic pulse_clr(input string tag);
    clr = 1'b1;
    tick(1);
    clr = 1'b0;
    chk({tag, ".clr_rdy"}, 32'(bus8.rdy), 32'd0);
    chk({tag, ".clr_flags"}, 32'({bus8.parity_err, bus8.frame_err, bus8.overrun}), 32'd0);
  endtask

  // Drives one frame on the line; extra_low replaces the second stop slot with a low bit.
  task automatic send_frame(input logic [8:0] data, input int nbits, input int b,
                            input int pm, input int pbit, input int cfgtwo, input int extra_low);
    cfg_baud  = 13'(b);
    cfg_pmode = 2'(pm);
    cfg_two   = 1'(cfgtwo);
    line      = 1'b0;
    start_cyc = cyc;
    tick(b);
    if (scramble) begin
      cfg_baud  = 13'($urandom_range(4, 40));
      cfg_pmode = 2'($urandom_range(0, 3));
      cfg_two   = 1'($urandom_range(0, 1));
    end
    for (int i = 0; i < nbits; i++) begin
      line = data[i];
      tick(b);
    end
    if (pm == 1 || pm == 2) begin
      line = 1'(pbit);
      tick(b);
    end
    line = 1'b1;
    if (clr_in_stop) begin
      clr      = 1'b1;
      clr_seen = 1'b0;
      for (int i = 0; i < b; i++) begin
        tick(1);
        if (!clr_seen && bus8.rdy) begin
          clr_seen = 1'b1;
          clr      = 1'b0;
        end
      end
      clr = 1'b0;
    end else begin
      tick(b);
    end
    if (extra_low != 0) begin
      line = 1'b0;
      tick(b);
    end else if (cfgtwo != 0) begin
      line = 1'b1;
      tick(b);
    end
    line = 1'b1;
  endtask

  function automatic logic model_perr(input logic [7:0] d, input int pm, input int pbit);
    int ones;
    ones = $countones(d) + pbit;
    if (pm == 1) return (ones % 2) == 1;
    if (pm == 2) return (ones % 2) == 0;
    return 1'b0;
  endfunction

  initial begin
    int r0;
    int lat;
    vecs[0] = '{8'hA5, 0, 0, 0, 0, 8'hA5, 1'b0, 1'b0};
    vecs[1] = '{8'h03, 1, 0, 0, 0, 8'h03, 1'b0, 1'b0};
    vecs[2] = '{8'h03, 1, 1, 0, 0, 8'h03, 1'b1, 1'b0};
    vecs[3] = '{8'h03, 2, 0, 0, 0, 8'h03, 1'b1, 1'b0};
    vecs[4] = '{8'h03, 2, 1, 0, 0, 8'h03, 1'b0, 1'b0};
    vecs[5] = '{8'h3C, 3, 0, 0, 0, 8'h3C, 1'b0, 1'b0};
    vecs[6] = '{8'h81, 0, 0, 1, 1, 8'h81, 1'b0, 1'b1};
    vecs[7] = '{8'h81, 0, 0, 1, 0, 8'h81, 1'b0, 1'b0};
    vecs[8] = '{8'h7F, 1, 1, 1, 1, 8'h7F, 1'b0, 1'b1};
    vecs[9] = '{8'hE0, 2, 0, 0, 0, 8'hE0, 1'b0, 1'b0};

    line = 1'b1; sel5 = 1'b0; cfg_baud = 13'd16; cfg_pmode = 2'b00; cfg_two = 1'b0;
    clr = 1'b0; scramble = 1'b0; clr_in_stop = 1'b0; clr_seen = 1'b0;
    rst = 1'b1;
    tick(3);
    rst = 1'b0;
    chk_out("reset", 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    tick(4);

    for (int v = 0; v < 10; v++) begin
      r0 = rise_cnt;
      send_frame({1'b0, vecs[v].data}, 8, 16, vecs[v].pm, vecs[v].pbit, vecs[v].two, vecs[v].low2);
      tick(32);
      if (v == 0) begin
        lat = rise_cyc - start_cyc;
        chk("latency_in_10pm1_bits", 32'(lat >= 144 && lat <= 176), 32'd1);
      end
      chk($sformatf("vec%0d.rdy_rises", v), 32'(rise_cnt - r0), 32'd1);
      chk_out($sformatf("vec%0d", v), vecs[v].exp_data, vecs[v].exp_perr, vecs[v].exp_ferr, 1'b1, 1'b0);
      $display("vec %0d data=%02h perr=%0b ferr=%0b", v, bus8.rx_data, bus8.parity_err, bus8.frame_err);
      pulse_clr($sformatf("vec%0d", v));
    end

    // Low bit after a single stop bit starts a new frame of all ones.
    send_frame(9'h081, 8, 16, 0, 0, 0, 1);
    chk_out("b2b.first", 8'h81, 1'b0, 1'b0, 1'b1, 1'b0);
    tick(16 * 12);
    chk_out("b2b.second", 8'hFF, 1'b0, 1'b0, 1'b1, 1'b1);
    $display("b2b data=%02h overrun=%0b", bus8.rx_data, bus8.overrun);
    pulse_clr("b2b");

    send_frame(9'h011, 8, 16, 0, 0, 0, 0);
    tick(32);
    send_frame(9'h022, 8, 16, 0, 0, 0, 0);
    tick(32);
    chk_out("overrun", 8'h22, 1'b0, 1'b0, 1'b1, 1'b1);
    $display("overrun data=%02h overrun=%0b", bus8.rx_data, bus8.overrun);
    pulse_clr("overrun");

    send_frame(9'h011, 8, 16, 0, 0, 0, 0);
    tick(32);
    clr_in_stop = 1'b1;
    send_frame(9'h055, 8, 16, 1, 1, 0, 0);
    clr_in_stop = 1'b0;
    tick(8);
    chk("commit_vs_clr.seen", 32'(clr_seen), 32'd1);
    chk_out("commit_vs_clr", 8'h55, 1'b1, 1'b0, 1'b1, 1'b0);
    $display("commit_vs_clr data=%02h perr=%0b", bus8.rx_data, bus8.parity_err);
    pulse_clr("commit_vs_clr");

    r0 = rise_cnt;
    line = 1'b0;
    tick(3);
    line = 1'b1;
    tick(48);
    chk("glitch.no_rdy", 32'(rise_cnt - r0), 32'd0);
    send_frame(9'h05A, 8, 16, 0, 0, 0, 0);
    tick(32);
    chk_out("glitch.next", 8'h5A, 1'b0, 1'b0, 1'b1, 1'b0);
    $display("glitch then data=%02h", bus8.rx_data);

    // rdy is still set from the previous frame so the reset has something to clear.
    line = 1'b0; tick(16);
    line = 1'b1; tick(16);
    line = 1'b0; tick(8);
    rst = 1'b1;
    line = 1'b1;
    tick(1);
    rst = 1'b0;
    chk_out("rst_mid", 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    tick(48);
    chk("rst_mid.no_late_rdy", 32'(bus8.rdy), 32'd0);
    send_frame(9'h0C3, 8, 16, 0, 0, 0, 0);
    tick(32);
    chk_out("rst_mid.next", 8'hC3, 1'b0, 1'b0, 1'b1, 1'b0);
    $display("after reset data=%02h", bus8.rx_data);
    pulse_clr("rst_mid");

    line = 1'b0;
    tick(16 * 14);
    chk_out("break", 8'h00, 1'b0, 1'b1, 1'b1, 1'b0);
    pulse_clr("break");
    tick(16 * 4);
    chk("break.no_retrigger", 32'(bus8.rdy), 32'd0);
    line = 1'b1;
    tick(32);
    send_frame(9'h096, 8, 16, 0, 0, 0, 0);
    tick(32);
    chk_out("break.next", 8'h96, 1'b0, 1'b0, 1'b1, 1'b0);
    $display("break then data=%02h", bus8.rx_data);
    pulse_clr("break.next");

    scramble = 1'b1;
    for (int n = 0; n < 24; n++) begin
      int b, pm, two, pbit;
      logic [7:0] d;
      logic ep;
      b    = $urandom_range(6, 24);
      d    = 8'($urandom);
      pm   = $urandom_range(0, 3);
      two  = $urandom_range(0, 1);
      pbit = $urandom_range(0, 1);
      ep   = model_perr(d, pm, pbit);
      send_frame({1'b0, d}, 8, b, pm, pbit, two, 0);
      tick(2 * b + $urandom_range(0, 5));
      chk_out($sformatf("rnd%0d", n), d, ep, 1'b0, 1'b1, 1'b0);
      $display("rnd %0d baud=%0d pm=%0d two=%0d data=%02h perr=%0b", n, b, pm, two, bus8.rx_data, bus8.parity_err);
      pulse_clr($sformatf("rnd%0d", n));
    end
    scramble = 1'b0;

    sel5 = 1'b1;
    send_frame(9'h015, 5, 16, 0, 0, 0, 0);
    tick(32);
    chk("w5.rx_data", 32'(bus5.rx_data), 32'h15);
    chk("w5.rdy", 32'(bus5.rdy), 32'd1);
    chk("w5.frame_err", 32'(bus5.frame_err), 32'd0);
    $display("w5 data=%02h", bus5.rx_data);
    sel5 = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
